// File: rtl/adc_xy_fb_scale.sv
// ADC XY code to framebuffer coordinate stage: scale/clamp/optional Y flip in S1,
// output register with optional duplicate-point suppression in S2.
module adc_xy_fb_scale #(
   parameter  int ADC_DATA_BITS = 10,
   parameter  int H_VISIBLE     = 640,
   parameter  int V_VISIBLE     = 480,
   parameter  int INVERT_Y      = 1,
   parameter  int DEDUP         = 1,
   parameter  int CNT_BITS      = 16,
   localparam int FB_X_BITS     = $clog2(H_VISIBLE),
   localparam int FB_Y_BITS     = $clog2(V_VISIBLE)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [ADC_DATA_BITS-1:0] s_x,
   input  logic [ADC_DATA_BITS-1:0] s_y,
   input  logic                     frame_start,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [FB_X_BITS-1:0]     m_x,
   output logic [FB_Y_BITS-1:0]     m_y,
   output logic [CNT_BITS-1:0]      drop_count
);

   localparam int SC_BITS = (FB_X_BITS > FB_Y_BITS) ? FB_X_BITS : FB_Y_BITS;
   localparam int PW      = ADC_DATA_BITS + SC_BITS + 1;

   logic [PW-1:0]        w_prod_x, w_prod_y;
   logic [PW-1:0]        w_sx_full, w_sy_full;
   logic [FB_X_BITS-1:0] w_sx;
   logic [FB_Y_BITS-1:0] w_sy_clamp, w_sy;
   logic                 w_out_free, w_adv, w_accept, w_match, w_dup, w_load;

   logic                 r_s1_valid;
   logic [FB_X_BITS-1:0] r_s1_x;
   logic [FB_Y_BITS-1:0] r_s1_y;
   logic                 r_m_valid;
   logic [FB_X_BITS-1:0] r_m_x;
   logic [FB_Y_BITS-1:0] r_m_y;
   logic                 r_last_valid;
   logic [CNT_BITS-1:0]  r_drop_cnt;

   assign w_prod_x  = PW'(s_x) * PW'(H_VISIBLE);
   assign w_prod_y  = PW'(s_y) * PW'(V_VISIBLE);
   assign w_sx_full = w_prod_x >> ADC_DATA_BITS;
   assign w_sy_full = w_prod_y >> ADC_DATA_BITS;

   always_comb begin
      w_sx       = (w_sx_full > PW'(H_VISIBLE - 1)) ? FB_X_BITS'(H_VISIBLE - 1)
                                                    : w_sx_full[FB_X_BITS-1:0];
      w_sy_clamp = (w_sy_full > PW'(V_VISIBLE - 1)) ? FB_Y_BITS'(V_VISIBLE - 1)
                                                    : w_sy_full[FB_Y_BITS-1:0];
      w_sy       = (INVERT_Y != 0) ? FB_Y_BITS'(V_VISIBLE - 1) - w_sy_clamp : w_sy_clamp;
   end

   assign w_out_free = ~r_m_valid | m_ready;
   assign w_adv      = r_s1_valid & w_out_free;
   assign s_ready    = ~r_s1_valid | w_out_free;
   assign w_accept   = s_valid & s_ready;

   // The output register always holds the last emitted point, so it doubles as
   // the dedup memory; r_last_valid says whether that memory is meaningful.
   assign w_match = (r_s1_x == r_m_x) && (r_s1_y == r_m_y);
   assign w_dup   = (DEDUP != 0) && r_last_valid && !frame_start && w_match;
   assign w_load  = w_adv & ~w_dup;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid   <= 1'b0;
         r_s1_x       <= '0;
         r_s1_y       <= '0;
         r_m_valid    <= 1'b0;
         r_m_x        <= '0;
         r_m_y        <= '0;
         r_last_valid <= 1'b0;
         r_drop_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_x     <= w_sx;
            r_s1_y     <= w_sy;
         end else if (w_adv) begin
            r_s1_valid <= 1'b0;
         end

         if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_x     <= r_s1_x;
            r_m_y     <= r_s1_y;
         end else if (m_ready) begin
            r_m_valid <= 1'b0;
         end

         if (w_load) begin
            r_last_valid <= 1'b1;
         end else if (frame_start) begin
            r_last_valid <= 1'b0;
         end

         if (w_adv && w_dup && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   assign m_valid    = r_m_valid;
   assign m_x        = r_m_x;
   assign m_y        = r_m_y;
   assign drop_count = r_drop_cnt;

endmodule
